// File: rtl/uncached_axi_bridge_pkg.sv
// Shared cpu package: AXI channel payloads, response/burst encodings and bridge FSM states.
package uncached_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned ID_W   = 4;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_e;

  // Master-driven AXI signals: AR, AW, W plus the R/B ready lines.
  typedef struct packed {
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              rready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              bready;
  } axi_req_t;

  // Slave-driven AXI signals: address/data readies plus the R and B channels.
  typedef struct packed {
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              awready;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
  } axi_resp_t;

endpackage

// File: rtl/uncached_axi_bridge.sv
// Single-outstanding bridge from the core's uncached data bus to one AXI single-beat transfer.
module uncached_axi_bridge
  import uncached_axi_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output axi_req_t          axi_req,
  input  axi_resp_t         axi_resp
);

  state_e            state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              data_ok_q, data_ok_d;
  logic              rerr_q, rerr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Direction and the reserved size bit are kept for the captured request but drive nothing.
  logic unused_c;
  assign unused_c = ^{wr_q, size_q[2]};

  // A request is taken only when nothing is in flight.
  assign addr_ok = req && (state_q == IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      wstrb_q   <= '0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      data_ok_q <= data_ok_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
      wr_q      <= wr_d;
      wstrb_q   <= wstrb_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next state; valid/ready flops are set on entry to a phase and cleared by their handshake.
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    data_ok_d = 1'b0;
    rerr_d    = rerr_q;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
    wstrb_d   = wstrb_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr;
          wstrb_d = wstrb;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          if (wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (axi_resp.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        // Only the final beat completes the load; stray non-last beats are dropped.
        if (axi_resp.rvalid && axi_resp.rlast) begin
          rdata_d   = axi_resp.rdata;
          rerr_d    = (axi_resp.rresp != AXI_RESP_OKAY);
          rready_d  = 1'b0;
          data_ok_d = 1'b1;
          state_d   = DONE;
        end
      end
      WR_REQ: begin
        if (axi_resp.awready) awvalid_d = 1'b0;
        if (axi_resp.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi_resp.bvalid) begin
          rerr_d    = (axi_resp.bresp != AXI_RESP_OKAY);
          bready_d  = 1'b0;
          data_ok_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // AXI payload is a fixed single-beat INCR transfer built from the captured request.
  always_comb begin
    axi_req         = '0;
    axi_req.arid    = AXI_ID;
    axi_req.araddr  = addr_q;
    axi_req.arlen   = 8'd0;
    axi_req.arsize  = {1'b0, size_q[1:0]};
    axi_req.arburst = AXI_BURST_INCR;
    axi_req.arvalid = arvalid_q;
    axi_req.rready  = rready_q;
    axi_req.awid    = AXI_ID;
    axi_req.awaddr  = addr_q;
    axi_req.awlen   = 8'd0;
    axi_req.awsize  = {1'b0, size_q[1:0]};
    axi_req.awburst = AXI_BURST_INCR;
    axi_req.awvalid = awvalid_q;
    axi_req.wdata   = wdata_q;
    axi_req.wstrb   = wstrb_q;
    axi_req.wlast   = 1'b1;
    axi_req.wvalid  = wvalid_q;
    axi_req.bready  = bready_q;
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
  assign rerr    = rerr_q;

endmodule

// File: doc/uncached_axi_bridge.md
UNCACHED_AXI_BRIDGE -- requirements
Module: uncached_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'd1: ID driven on all AR/AW channels.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  uncached data access request from the core data bus.
REQ-005 wr  input  1  1 = store, 0 = load; valid with req.
REQ-006 wstrb  input  4  store byte enables.
REQ-007 size  input  3  access size: 0 byte, 1 half, 2 word; others illegal.
REQ-008 addr  input  32  physical byte address.
REQ-009 wdata  input  32  store data.
REQ-010 addr_ok  output  1  request accepted this cycle.
REQ-011 data_ok  output  1  transaction complete, one-cycle pulse.
REQ-012 rdata  output  32  load data, valid with data_ok for loads.
REQ-013 rerr  output  1  AXI response was not OKAY; valid with data_ok.
REQ-014 axi_req  output  axi_req_t  AR, AW, W channel signals plus rready and bready.
REQ-015 axi_resp  input  axi_resp_t  arready, awready, wready, R and B channel signals.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-017 addr_ok SHALL be combinational: req && state==IDLE.
REQ-018 At most one transaction outstanding: no addr_ok from acceptance until the cycle after the data_ok pulse.
REQ-019 On acceptance the block SHALL register wr, wstrb, size, addr and wdata, then go to RD_ADDR (load) or WR_REQ (store).
REQ-020 RD_ADDR SHALL hold arvalid=1 with stable araddr and arsize until arready, then go to RD_DATA.
REQ-021 RD_ADDR AR fields: arlen=0, arburst=INCR, arid=AXI_ID.
REQ-022 RD_DATA SHALL hold rready=1.
REQ-023 In RD_DATA, on rvalid the block SHALL register rdata and rerr=(rresp!=0), then go to DONE.
REQ-024 WR_REQ SHALL raise awvalid and wvalid together, with wlast=1.
REQ-025 Each of awvalid and wvalid SHALL drop independently after its own handshake; either order, or the same cycle, SHALL be handled.
REQ-026 WR_REQ SHALL go to WR_RESP once both the AW and W handshakes have completed.
REQ-027 WR_RESP SHALL hold bready=1.
REQ-028 In WR_RESP, on bvalid the block SHALL register rerr=(bresp!=0), then go to DONE.
REQ-029 DONE SHALL assert data_ok for exactly one cycle, then return to IDLE.
REQ-030 data_ok SHALL be a registered output.
REQ-031 axsize SHALL equal size[1:0] for both reads and writes.
REQ-032 Addresses SHALL be passed through unmodified.
REQ-033 wstrb SHALL be passed through unmodified.
REQ-034 Minimum load latency with zero-wait slave: addr_ok cycle 0, arvalid cycle 1, rvalid cycle 2, data_ok cycle 3.
REQ-035 Minimum store latency: AW/W cycle 1, bvalid cycle 2, data_ok cycle 3.
REQ-036 An R beat with rlast=0, or an unexpected rvalid/bvalid, SHALL be ignored outside RD_DATA/WR_RESP.
REQ-037 rdata and rerr SHALL hold their last values until the next completion.

Reset
REQ-038 Reset SHALL force state=IDLE.
REQ-039 Reset SHALL force all valid, ready, data_ok and rerr outputs to 0.
REQ-040 Reset SHALL force rdata and the captured registers to 0.
REQ-041 Reset asserted mid-transaction SHALL abandon the transaction; no data_ok SHALL follow.

Structure
REQ-042 axi_req_t, axi_resp_t, the AXI_RESP_OKAY/AXI_BURST_INCR constants and the FSM state enum SHALL reside in the shared cpu package.
REQ-043 The block SHALL be a single module with no sub-modules.

Verification
REQ-044 Zero-wait slave, load addr=0x1FAF_F004, size=2, slave returns 0xDEAD_BEEF -> data_ok at cycle 3, rdata=0xDEAD_BEEF, rerr=0.
REQ-045 Store with wstrb=4'b0011, wdata=0x0000_1234; wready 3 cycles before awready -> single AW and single W handshake, data_ok one cycle after bvalid.
REQ-046 Second req held high during an outstanding load -> addr_ok=0 until after data_ok; second request then accepted.
REQ-047 Slave returns rresp=2'b10 (SLVERR) -> data_ok with rerr=1.
REQ-048 arready held low 10 cycles -> araddr and arvalid remain stable throughout.
REQ-049 Reset pulsed while in WR_RESP -> IDLE, all valids low, no data_ok issued.
